mrv1_twctl_unit: RTL

MRV1_TWCTL_UNIT -- requirements
Module: mrv1_twctl_unit

---
 rtl/mrv1_twctl_pkg.sv | 30 +++
 rtl/mrv1_ipdom_stack.sv | 57 +++++
 rtl/mrv1_twctl_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mrv1_twctl_pkg.sv
// Shared types for the thread/warp control unit: op codes, FSM states and
// the IPDOM reconvergence stack entry.
package mrv1_twctl_pkg;

  localparam int MAX_MASK_W = 32;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_TMC    = 3'd1,
    OP_WSPAWN = 3'd2,
    OP_SPLIT  = 3'd3,
    OP_JOIN   = 3'd4,
    OP_BAR    = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STKRD = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  // Masks are stored at the maximum width; only the low warp_size_p bits matter.
  typedef struct packed {
    logic [MAX_MASK_W-1:0] orig;
    logic [MAX_MASK_W-1:0] else_mask;
    logic [31:0]           else_pc;
    logic                  taken;
  } ipdom_entry_t;

endpackage

// File: rtl/mrv1_ipdom_stack.sv
// Per-warp IPDOM stacks: push, mark-top-taken, pop, and a registered top read.
module mrv1_ipdom_stack
  import mrv1_twctl_pkg::*;
#(
  parameter int NUM_TW_P      = 8,
  parameter int ipdom_depth_p = 4,
  localparam int wid_width_lp = $clog2(NUM_TW_P)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rd_en_i,
  input  logic [wid_width_lp-1:0] rd_twid_i,
  output ipdom_entry_t            rd_entry_o,
  input  logic [wid_width_lp-1:0] wr_twid_i,
  input  logic                    push_i,
  input  ipdom_entry_t            push_entry_i,
  input  logic                    upd_i,
  input  logic                    pop_i,
  output logic [NUM_TW_P-1:0]     full_o,
  output logic [NUM_TW_P-1:0]     empty_o
);

  localparam int PW = $clog2(ipdom_depth_p + 1);
  localparam int IW = $clog2(ipdom_depth_p);

  logic [PW-1:0] ptr [NUM_TW_P];
  ipdom_entry_t  mem [NUM_TW_P][ipdom_depth_p];
  logic [IW-1:0] wr_idx, wr_top, rd_top;

  always_comb begin
    wr_idx = IW'(ptr[wr_twid_i]);
    wr_top = IW'(ptr[wr_twid_i] - 1'b1);
    rd_top = IW'(ptr[rd_twid_i] - 1'b1);
    for (int unsigned i = 0; i < NUM_TW_P; i++) begin
      full_o[i]  = (ptr[i] == PW'(ipdom_depth_p));
      empty_o[i] = (ptr[i] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_TW_P; i++) ptr[i] <= '0;
    end else if (push_i) begin
      ptr[wr_twid_i] <= ptr[wr_twid_i] + 1'b1;
    end else if (pop_i) begin
      ptr[wr_twid_i] <= ptr[wr_twid_i] - 1'b1;
    end
  end

  // Entry storage needs no reset: pointers alone define what is live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_twid_i][wr_idx] <= push_entry_i;
    else if (upd_i) mem[wr_twid_i][wr_top].taken <= 1'b1;
    if (rd_en_i) rd_entry_o <= mem[rd_twid_i][rd_top];
  end

endmodule

// File: rtl/mrv1_twctl_unit.sv
// Thread/warp control unit: decodes TMC/WSPAWN/SPLIT/JOIN/BAR requests,
// stalls the issuing warp and emits one registered control pulse per request.
module mrv1_twctl_unit
  import mrv1_twctl_pkg::*;
#(
  parameter int NUM_TW_P       = 8,
  parameter int warp_size_p    = 8,
  parameter int num_barriers_p = 8,
  parameter int ipdom_depth_p  = 4,
  localparam int barrier_id_width_lp = $clog2(num_barriers_p),
  localparam int wid_width_lp        = $clog2(NUM_TW_P)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_vld_i,
  output logic                           req_rdy_o,
  input  logic [2:0]                     req_op_i,
  input  logic [wid_width_lp-1:0]        req_twid_i,
  input  logic [31:0]                    req_pc_i,
  input  logic [warp_size_p-1:0]         req_tmask_i,
  input  logic [warp_size_p-1:0]         req_pred_i,
  input  logic [31:0]                    req_rs1_i,
  input  logic [31:0]                    req_rs2_i,
  output logic                           wstall_vld_o,
  output logic [wid_width_lp-1:0]        wstall_twid_o,
  output logic                           twctl_vld_o,
  output logic [wid_width_lp-1:0]        twctl_twid_o,
  output logic                           twctl_tmc_vld_o,
  output logic [warp_size_p-1:0]         twctl_tmc_tmask_o,
  output logic                           twctl_wspawn_vld_o,
  output logic [NUM_TW_P-1:0]            twctl_wspawn_wmask_o,
  output logic [31:0]                    twctl_wspawn_pc_o,
  output logic                           twctl_split_vld_o,
  output logic                           twctl_split_diverged_o,
  output logic [warp_size_p-1:0]         twctl_split_then_mask_o,
  output logic [warp_size_p-1:0]         twctl_split_else_mask_o,
  output logic [31:0]                    twctl_split_pc_o,
  output logic                           twctl_barrier_vld_o,
  output logic [barrier_id_width_lp-1:0] twctl_barrier_id_o,
  output logic [wid_width_lp-1:0]        twctl_barrier_size_m1_o,
  output logic                           join_vld_o,
  output logic [wid_width_lp-1:0]        join_twid_o,
  output logic [31:0]                    join_pc_o,
  output logic [warp_size_p-1:0]         join_tm_o,
  output logic                           join_fall_o,
  output logic                           err_overflow_o,
  output logic                           err_underflow_o
);

  state_e                  state;
  op_e                     lat_op;
  logic [wid_width_lp-1:0] lat_twid;
  logic [31:0]             lat_pc;
  logic [warp_size_p-1:0]  lat_tmask;

  logic                    op_ok, rd_en, push, upd, pop, diverged;
  logic [warp_size_p-1:0]  then_m, else_m;
  logic [31:0]             bar_m1;
  ipdom_entry_t            rd_entry, push_entry;
  logic [NUM_TW_P-1:0]     full, empty;
  logic                    unused_bits;

  always_comb begin
    op_ok         = (req_op_i >= 3'd1) && (req_op_i <= 3'd5);
    req_rdy_o     = (state == S_IDLE);
    wstall_vld_o  = (state == S_IDLE) && req_vld_i && op_ok;
    wstall_twid_o = req_twid_i;
    then_m        = req_tmask_i & req_pred_i;
    else_m        = req_tmask_i & ~req_pred_i;
    diverged      = (|then_m) && (|else_m);
    bar_m1        = (req_rs2_i == '0) ? '0 : req_rs2_i - 32'd1;
    rd_en         = (state == S_IDLE) && req_vld_i && (req_op_i == OP_JOIN);
    upd           = (state == S_STKRD) && !empty[lat_twid] && !rd_entry.taken;
    pop           = (state == S_STKRD) && !empty[lat_twid] && rd_entry.taken;
    // Split outputs already carry diverged=0 when the stack was full at accept.
    push          = (state == S_ISSUE) && (lat_op == OP_SPLIT) && twctl_split_diverged_o;
    push_entry                          = '0;
    push_entry.orig[warp_size_p-1:0]      = lat_tmask;
    push_entry.else_mask[warp_size_p-1:0] = twctl_split_else_mask_o;
    push_entry.else_pc                  = lat_pc + 32'd4;
  end

  assign unused_bits = ^{rd_entry.orig, rd_entry.else_mask, req_rs1_i, req_rs2_i, bar_m1};

  mrv1_ipdom_stack #(
    .NUM_TW_P      (NUM_TW_P),
    .ipdom_depth_p (ipdom_depth_p)
  ) u_stack (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_en_i      (rd_en),
    .rd_twid_i    (req_twid_i),
    .rd_entry_o   (rd_entry),
    .wr_twid_i    (lat_twid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .upd_i        (upd),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                   <= S_IDLE;
      lat_op                  <= OP_NOP;
      lat_twid                <= '0;
      lat_pc                  <= '0;
      lat_tmask               <= '0;
      twctl_vld_o             <= 1'b0;
      twctl_twid_o            <= '0;
      twctl_tmc_vld_o         <= 1'b0;
      twctl_tmc_tmask_o       <= '0;
      twctl_wspawn_vld_o      <= 1'b0;
      twctl_wspawn_wmask_o    <= '0;
      twctl_wspawn_pc_o       <= '0;
      twctl_split_vld_o       <= 1'b0;
      twctl_split_diverged_o  <= 1'b0;
      twctl_split_then_mask_o <= '0;
      twctl_split_else_mask_o <= '0;
      twctl_split_pc_o        <= '0;
      twctl_barrier_vld_o     <= 1'b0;
      twctl_barrier_id_o      <= '0;
      twctl_barrier_size_m1_o <= '0;
      join_vld_o              <= 1'b0;
      join_twid_o             <= '0;
      join_pc_o               <= '0;
      join_tm_o               <= '0;
      join_fall_o             <= 1'b0;
      err_overflow_o          <= 1'b0;
      err_underflow_o         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_vld_i && op_ok) begin
            lat_op       <= op_e'(req_op_i);
            lat_twid     <= req_twid_i;
            lat_pc       <= req_pc_i;
            lat_tmask    <= req_tmask_i;
            twctl_twid_o <= req_twid_i;
            state        <= (req_op_i == OP_JOIN) ? S_STKRD : S_ISSUE;
            case (req_op_i)
              OP_TMC: begin
                twctl_vld_o       <= 1'b1;
                twctl_tmc_vld_o   <= 1'b1;
                twctl_tmc_tmask_o <= req_rs1_i[warp_size_p-1:0];
              end
              OP_WSPAWN: begin
                twctl_vld_o          <= 1'b1;
                twctl_wspawn_vld_o   <= 1'b1;
                twctl_wspawn_wmask_o <= req_rs1_i[NUM_TW_P-1:0];
                twctl_wspawn_pc_o    <= req_rs2_i;
              end
              OP_SPLIT: begin
                twctl_vld_o       <= 1'b1;
                twctl_split_vld_o <= 1'b1;
                twctl_split_pc_o  <= req_pc_i;
                if (diverged && full[req_twid_i]) begin
                  twctl_split_diverged_o  <= 1'b0;
                  twctl_split_then_mask_o <= req_tmask_i;
                  twctl_split_else_mask_o <= '0;
                  err_overflow_o          <= 1'b1;
                end else begin
                  twctl_split_diverged_o  <= diverged;
                  twctl_split_then_mask_o <= then_m;
                  twctl_split_else_mask_o <= else_m;
                end
              end
              OP_BAR: begin
                twctl_vld_o             <= 1'b1;
                twctl_barrier_vld_o     <= 1'b1;
                twctl_barrier_id_o      <= req_rs1_i[barrier_id_width_lp-1:0];
                twctl_barrier_size_m1_o <= bar_m1[wid_width_lp-1:0];
              end
              default: ;
            endcase
          end
        end
        S_STKRD: begin
          state       <= S_ISSUE;
          join_vld_o  <= 1'b1;
          join_twid_o <= lat_twid;
          if (empty[lat_twid]) begin
            join_tm_o       <= lat_tmask;
            join_pc_o       <= '0;
            join_fall_o     <= 1'b1;
            err_underflow_o <= 1'b1;
          end else if (rd_entry.taken) begin
            join_tm_o   <= rd_entry.orig[warp_size_p-1:0];
            join_pc_o   <= '0;
            join_fall_o <= 1'b1;
          end else begin
            join_tm_o   <= rd_entry.else_mask[warp_size_p-1:0];
            join_pc_o   <= rd_entry.else_pc;
            join_fall_o <= 1'b0;
          end
        end
        S_ISSUE: begin
          state               <= S_IDLE;
          twctl_vld_o         <= 1'b0;
          twctl_tmc_vld_o     <= 1'b0;
          twctl_wspawn_vld_o  <= 1'b0;
          twctl_split_vld_o   <= 1'b0;
          twctl_barrier_vld_o <= 1'b0;
          join_vld_o          <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
